// File: rtl/aira_ml_pkg.sv
// Shared definitions for the aira_ml output path.
//   ser_state_t : serialiser FSM states (idle, address bytes, data bytes)
//   bytes_for() : number of whole bytes needed to carry a field of the given bit width
package aira_ml_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSendAddr,
    StSendData
  } ser_state_t;

  function automatic int unsigned bytes_for(input int unsigned width);
    return (width + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/aira_ml_output_serialiser.sv
// Buffers one aira_ml output beat (all ports' words and addresses) and emits it as a
// little-endian byte stream under a valid/ready handshake: port 0 address, port 0 data,
// port 1 address, ... Addresses are zero-extended and data sign-extended to whole bytes.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   i_data         per-port network output words (two's complement)
//   i_d_addr       per-port word addresses
//   i_d_valid      beat valid; only sampled while idle
//   o_stall        registered busy flag toward the network (upstream holds its beat)
//   o_byte         serial byte
//   o_byte_valid   o_byte is valid
//   o_byte_last    o_byte is the final byte of the beat
//   i_byte_ready   sink accepts the current byte
module aira_ml_output_serialiser
  import aira_ml_pkg::*;
#(
  parameter int unsigned N_MODULE_OUTPUT       = 16,
  parameter int unsigned N_MODULE_OUTPUT_ADDR  = 8,
  parameter int unsigned N_MODULE_OUTPUT_PORTS = 1
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [N_MODULE_OUTPUT_PORTS-1:0][N_MODULE_OUTPUT-1:0]      i_data,
  input  logic [N_MODULE_OUTPUT_PORTS-1:0][N_MODULE_OUTPUT_ADDR-1:0] i_d_addr,
  input  logic                                                    i_d_valid,
  output logic                                                    o_stall,
  output logic [7:0]                                              o_byte,
  output logic                                                    o_byte_valid,
  output logic                                                    o_byte_last,
  input  logic                                                    i_byte_ready
);

  localparam int unsigned N_DATA_BYTES = bytes_for(N_MODULE_OUTPUT);
  localparam int unsigned N_ADDR_BYTES = bytes_for(N_MODULE_OUTPUT_ADDR);
  localparam int unsigned N_BEAT_BYTES = N_MODULE_OUTPUT_PORTS * (N_ADDR_BYTES + N_DATA_BYTES);

  // Both fields are extended to a common width so one byte counter and one offset serve both.
  localparam int unsigned NMaxBytes = (N_ADDR_BYTES > N_DATA_BYTES) ? N_ADDR_BYTES : N_DATA_BYTES;
  localparam int unsigned ExtW      = NMaxBytes * 8;
  localparam int unsigned BW        = (NMaxBytes > 1) ? $clog2(NMaxBytes) : 1;
  localparam int unsigned PW        = (N_MODULE_OUTPUT_PORTS > 1) ? $clog2(N_MODULE_OUTPUT_PORTS) : 1;
  localparam int unsigned OffW      = BW + 3;

  localparam logic [BW-1:0] LastAddrByte = BW'(N_ADDR_BYTES - 1);
  localparam logic [BW-1:0] LastDataByte = BW'(N_DATA_BYTES - 1);
  localparam logic [PW-1:0] LastPort     = PW'(N_MODULE_OUTPUT_PORTS - 1);

  ser_state_t state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [BW-1:0] b_q, b_d;
  logic          stall_q, stall_d;

  logic [N_MODULE_OUTPUT_PORTS-1:0][N_MODULE_OUTPUT-1:0]      hold_data_q, hold_data_d;
  logic [N_MODULE_OUTPUT_PORTS-1:0][N_MODULE_OUTPUT_ADDR-1:0] hold_addr_q, hold_addr_d;

  logic [N_MODULE_OUTPUT_PORTS-1:0][ExtW-1:0] addr_ext;
  logic [N_MODULE_OUTPUT_PORTS-1:0][ExtW-1:0] data_ext;
  logic [OffW-1:0]                            bit_off;
  logic                                       handshake;

  always_comb begin
    for (int i = 0; i < int'(N_MODULE_OUTPUT_PORTS); i++) begin
      addr_ext[i] = ExtW'(hold_addr_q[i]);
      data_ext[i] = ExtW'($signed(hold_data_q[i]));
    end
  end

  assign bit_off   = {b_q, 3'b000};
  assign handshake = o_byte_valid & i_byte_ready;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    b_d         = b_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;

    case (state_q)
      StIdle: begin
        if (i_d_valid) begin
          hold_data_d = i_data;
          hold_addr_d = i_d_addr;
          state_d     = StSendAddr;
          p_d         = '0;
          b_d         = '0;
        end
      end
      StSendAddr: begin
        if (handshake) begin
          if (b_q == LastAddrByte) begin
            state_d = StSendData;
            b_d     = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      StSendData: begin
        if (handshake) begin
          if (b_q == LastDataByte) begin
            b_d = '0;
            if (p_q == LastPort) begin
              state_d = StIdle;
              p_d     = '0;
            end else begin
              state_d = StSendAddr;
              p_d     = p_q + 1'b1;
            end
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        p_d     = '0;
        b_d     = '0;
      end
    endcase

    stall_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      p_q         <= '0;
      b_q         <= '0;
      stall_q     <= 1'b0;
      hold_data_q <= '0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      b_q         <= b_d;
      stall_q     <= stall_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  // Outputs depend only on registered state, so they hold steady under backpressure.
  always_comb begin
    o_byte      = 8'h00;
    o_byte_last = 1'b0;
    case (state_q)
      StSendAddr: o_byte = addr_ext[p_q][bit_off +: 8];
      StSendData: begin
        o_byte      = data_ext[p_q][bit_off +: 8];
        o_byte_last = (p_q == LastPort) && (b_q == LastDataByte);
      end
      default: ;
    endcase
  end

  assign o_byte_valid = (state_q != StIdle);
  assign o_stall      = stall_q;

  initial begin : p_param_check
    assert (N_MODULE_OUTPUT >= 1 && N_MODULE_OUTPUT_ADDR >= 1 && N_MODULE_OUTPUT_PORTS >= 1)
      else $fatal(1, "aira_ml_output_serialiser: widths and port count must be >= 1");
    assert (N_BEAT_BYTES >= 2)
      else $fatal(1, "aira_ml_output_serialiser: beat must carry at least two bytes");
  end

endmodule

// File: tb/tb_aira_ml_output_serialiser.sv
// Self-checking bench for aira_ml_output_serialiser (12-bit data, 4-bit address, 2 ports).
module tb_aira_ml_output_serialiser;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned NAB = 1;
  localparam int unsigned NDB = 2;
  localparam int unsigned NBYTES = NP * (NAB + NDB);

  logic                    clk;
  logic                    rst;
  logic [NP-1:0][DW-1:0]   i_data;
  logic [NP-1:0][AW-1:0]   i_d_addr;
  logic                    i_d_valid;
  logic                    o_stall;
  logic [7:0]              o_byte;
  logic                    o_byte_valid;
  logic                    o_byte_last;
  logic                    i_byte_ready;

  int n_checks = 0;
  int n_fail   = 0;

  aira_ml_output_serialiser #(
    .N_MODULE_OUTPUT      (DW),
    .N_MODULE_OUTPUT_ADDR (AW),
    .N_MODULE_OUTPUT_PORTS(NP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_d_addr    (i_d_addr),
    .i_d_valid   (i_d_valid),
    .o_stall     (o_stall),
    .o_byte      (o_byte),
    .o_byte_valid(o_byte_valid),
    .o_byte_last (o_byte_last),
    .i_byte_ready(i_byte_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: each port contributes its address as unsigned bytes, then its data as a
  // signed integer split into little-endian bytes.
  function automatic logic [NBYTES-1:0][7:0] model_bytes(input logic [NP-1:0][AW-1:0] a,
                                                         input logic [NP-1:0][DW-1:0] d);
    logic [NBYTES-1:0][7:0] r;
    int k;
    k = 0;
    for (int p = 0; p < int'(NP); p++) begin
      int unsigned av;
      int          sv;
      av = int'(a[p]);
      for (int i = 0; i < int'(NAB); i++) begin
        r[k] = 8'((av >> (8 * i)) & 255);
        k++;
      end
      sv = int'(d[p]);
      if (sv >= (1 << (DW - 1))) sv = sv - (1 << DW);
      for (int i = 0; i < int'(NDB); i++) begin
        r[k] = 8'((sv >>> (8 * i)) & 255);
        k++;
      end
    end
    return r;
  endfunction

  task automatic check_quiet(input string name);
    chk({name, " stall"}, 32'(o_stall), 0);
    chk({name, " valid"}, 32'(o_byte_valid), 0);
    chk({name, " last"}, 32'(o_byte_last), 0);
    chk({name, " byte"}, 32'(o_byte), 0);
  endtask

  // Captures one beat (block must be idle), then drains it. Cycle k of the drain drives
  // ready low when stall_mask[k] is set. With violate, cycle 1 presents a different beat.
  task automatic run_beat(input logic [NP-1:0][AW-1:0] a, input logic [NP-1:0][DW-1:0] d,
                          input logic [NBYTES-1:0][7:0] exp, input logic [31:0] stall_mask,
                          input bit violate, input string name);
    int   idx = 0;
    int   cyc = 0;
    int   stall_cycles = 0;
    bit   prev_held = 0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_last = 1'b0;
    i_d_addr     = a;
    i_data       = d;
    i_d_valid    = 1'b1;
    i_byte_ready = 1'b0;
    step();
    i_d_valid = 1'b0;
    chk({name, " stall on capture"}, 32'(o_stall), 1);
    chk({name, " valid on capture"}, 32'(o_byte_valid), 1);
    while (idx < int'(NBYTES) && cyc < 64) begin
      if (o_stall) stall_cycles++;
      if (prev_held) begin
        chk({name, " hold byte"}, 32'(o_byte), 32'(prev_byte));
        chk({name, " hold last"}, 32'(o_byte_last), 32'(prev_last));
      end
      i_byte_ready = (cyc < 32) ? ~stall_mask[cyc] : 1'b1;
      if (violate && cyc == 1) begin
        i_d_addr  = ~a;
        i_data    = ~d;
        i_d_valid = 1'b1;
      end else begin
        i_d_valid = 1'b0;
      end
      if (o_byte_valid && i_byte_ready) begin
        chk($sformatf("%s byte%0d", name, idx), 32'(o_byte), 32'(exp[idx]));
        chk($sformatf("%s last%0d", name, idx), 32'(o_byte_last), 32'(idx == int'(NBYTES) - 1));
        idx++;
        prev_held = 0;
      end else begin
        prev_held = o_byte_valid;
        prev_byte = o_byte;
        prev_last = o_byte_last;
      end
      step();
      cyc++;
    end
    i_byte_ready = 1'b0;
    i_d_valid    = 1'b0;
    chk({name, " bytes drained"}, 32'(idx), NBYTES);
    chk({name, " stall after end"}, 32'(o_stall), 0);
    chk({name, " valid after end"}, 32'(o_byte_valid), 0);
    if (stall_mask == 32'h0) chk({name, " stall cycles"}, 32'(stall_cycles), NBYTES);
  endtask

  typedef struct {
    logic [NP-1:0][AW-1:0]   a;
    logic [NP-1:0][DW-1:0]   d;
    logic [NBYTES-1:0][7:0]  exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [NP-1:0][AW-1:0]  ra, rb;
    logic [NP-1:0][DW-1:0]  rd, re;
    logic [NBYTES-1:0][7:0] ea, eb;

    // Expected byte streams, first byte in the least-significant position.
    vecs[0].a = {4'h5, 4'h3}; vecs[0].d = {12'h123, 12'hABC}; vecs[0].exp = 48'h01_23_05_FA_BC_03;
    vecs[1].a = {4'h2, 4'h1}; vecs[1].d = {12'h7FF, 12'h001}; vecs[1].exp = 48'h07_FF_02_00_01_01;
    vecs[2].a = {4'h0, 4'hF}; vecs[2].d = {12'hFFF, 12'h800}; vecs[2].exp = 48'hFF_FF_00_F8_00_0F;
    vecs[3].a = {4'hA, 4'h0}; vecs[3].d = {12'h080, 12'h000}; vecs[3].exp = 48'h00_80_0A_00_00_00;

    rst          = 1'b0;
    i_data       = '0;
    i_d_addr     = '0;
    i_d_valid    = 1'b0;
    i_byte_ready = 1'b0;

    // Reset held with random inputs, then released with no beat offered.
    for (int i = 0; i < 4; i++) begin
      i_data       = NP * DW'($urandom());
      i_d_addr     = NP * AW'($urandom());
      i_d_valid    = 1'($urandom());
      i_byte_ready = 1'($urandom());
      step();
      check_quiet($sformatf("reset%0d", i));
    end
    i_d_valid = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet($sformatf("post-reset%0d", i));
    end

    // Table-driven beats with the sink always ready.
    foreach (vecs[i]) run_beat(vecs[i].a, vecs[i].d, vecs[i].exp, 32'h0, 0, $sformatf("vec%0d", i));

    // Backpressure: three ready-low cycles while the third byte (FA) is presented.
    run_beat(vecs[0].a, vecs[0].d, vecs[0].exp, 32'h0000_001C, 0, "backpressure");

    // Upstream changes and re-asserts valid while the beat is in flight.
    run_beat(vecs[0].a, vecs[0].d, vecs[0].exp, 32'h0, 1, "violation");

    // Reset after the second byte has been handshaked.
    i_d_addr = vecs[0].a; i_data = vecs[0].d; i_d_valid = 1'b1; i_byte_ready = 1'b1;
    step();
    i_d_valid = 1'b0;
    chk("midreset byte0", 32'(o_byte), 32'h03);
    step();
    chk("midreset byte1", 32'(o_byte), 32'hBC);
    step();
    rst = 1'b0;
    #1;
    check_quiet("midreset asserted");
    step();
    check_quiet("midreset held");
    rst = 1'b1;
    i_byte_ready = 1'b0;
    step();
    check_quiet("midreset released");
    run_beat(vecs[1].a, vecs[1].d, vecs[1].exp, 32'h0, 0, "after midreset");

    // Back-to-back beats with valid held high.
    begin
      int got = 0;
      int last_a = -100;
      int first_b = -1;
      ra = {4'h9, 4'h6}; rd = {12'h456, 12'hF0E};
      rb = {4'h4, 4'hC}; re = {12'h3A5, 12'h8C1};
      ea = model_bytes(ra, rd);
      eb = model_bytes(rb, re);
      i_d_addr = ra; i_data = rd; i_d_valid = 1'b1; i_byte_ready = 1'b1;
      step();
      i_d_addr = rb; i_data = re;
      for (int cyc = 0; cyc < 40 && got < 2 * int'(NBYTES); cyc++) begin
        if (o_byte_valid) begin
          if (got < int'(NBYTES))
            chk($sformatf("b2b A byte%0d", got), 32'(o_byte), 32'(ea[got]));
          else
            chk($sformatf("b2b B byte%0d", got - int'(NBYTES)), 32'(o_byte),
                32'(eb[got - int'(NBYTES)]));
          if (got == int'(NBYTES) - 1) last_a = cyc;
          if (got == int'(NBYTES)) begin
            first_b = cyc;
            i_d_valid = 1'b0;
          end
          got++;
        end
        step();
      end
      i_byte_ready = 1'b0;
      i_d_valid    = 1'b0;
      chk("b2b byte count", 32'(got), 2 * NBYTES);
      chk("b2b gap", 32'(first_b - last_a), 2);
      chk("b2b idle after", 32'(o_byte_valid), 0);
      step();
      chk("b2b no extra capture", 32'(o_stall), 0);
    end

    // Random beats, random backpressure and upstream violations against the model.
    for (int n = 0; n < 24; n++) begin
      for (int p = 0; p < int'(NP); p++) begin
        ra[p] = AW'($urandom());
        rd[p] = DW'($urandom());
      end
      run_beat(ra, rd, model_bytes(ra, rd), $urandom() & 32'h0000_0FFF, 1'($urandom()),
               $sformatf("rand%0d", n));
      if ($urandom_range(1) == 1) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
